// File: rtl/scrambler_seq_ctrl.sv
// Sequencer for the 7-step scrambler core: owns the 64-bit output LFSR state and the
// 411-bit P7 state, loads seeds, registers each beat behind a valid/ready handshake.
module scrambler_seq_ctrl #(
    parameter int unsigned RESEED_INTERVAL = 1024,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_valid,
    input  logic [63:0]      seed_p17,
    input  logic [410:0]     seed_p7,
    output logic             seed_ready,
    output logic             seed_req,
    output logic             seed_err,
    input  logic             in_valid,
    input  logic [6:0]       in_bits,
    output logic             in_ready,
    output logic             out_valid,
    output logic [63:0]      out_data,
    input  logic             out_ready,
    output logic [63:0]      core_load,
    output logic [410:0]     core_load_p7,
    output logic [6:0]       core_serial,
    input  logic [63:0]      core_out,
    output logic [CNT_W-1:0] beat_cnt
);

    localparam int unsigned P17_W = 64;
    localparam int unsigned P7_W  = 411;
    localparam int unsigned STEPS = 7;

    // Feedback taps of the P7 polynomial (bit k receives p7[k-1] ^ msb)
    localparam logic [P7_W-1:0] TAP_MASK = (P7_W'(1) << 31)  | (P7_W'(1) << 60)  |
                                           (P7_W'(1) << 190) | (P7_W'(1) << 195) |
                                           (P7_W'(1) << 245);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RESEED = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [P17_W-1:0]   p17;
    logic [P7_W-1:0]    p7;
    logic [P7_W-1:0]    p7_adv;
    logic [CNT_W-1:0]   cnt_inc;
    logic               seed_ok;
    logic               seed_zero;
    logic               beat_acc;
    logic               interval_hit;

    function automatic logic [P7_W-1:0] p7_step(input logic [P7_W-1:0] p, input logic d);
        logic m;
        m = p[P7_W-1];
        return {p[P7_W-2:0], m ^ d} ^ (TAP_MASK & {P7_W{m}});
    endfunction

    // Local 7-step P7 advance, identical to what the core consumes
    always_comb begin
        p7_adv = p7;
        for (int i = 0; i < int'(STEPS); i++) begin
            p7_adv = p7_step(p7_adv, in_bits[i]);
        end
    end

    assign seed_ok      = seed_valid && (seed_p7 != '0);
    assign seed_zero    = seed_valid && (seed_p7 == '0);
    assign beat_acc     = in_valid && in_ready;
    assign cnt_inc      = (beat_cnt == '1) ? beat_cnt : CNT_W'(beat_cnt + 1'b1);
    assign interval_hit = (RESEED_INTERVAL != 0) && (cnt_inc == CNT_W'(RESEED_INTERVAL));

    assign seed_ready   = 1'b1;
    assign core_load    = p17;
    assign core_load_p7 = p7;
    assign core_serial  = in_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (seed_ok) next_state = RUN;
            RUN:     if (beat_acc && interval_hit) next_state = RESEED;
            RESEED:  if (seed_ok) next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    // A seed in the same cycle always wins over a beat
    always_comb begin
        seed_req = 1'b1;
        in_ready = 1'b0;
        if (state == RUN) begin
            seed_req = 1'b0;
            in_ready = !seed_valid && (!out_valid || out_ready);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p17       <= '0;
            p7        <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            seed_err  <= 1'b0;
        end else begin
            if (seed_zero) begin
                seed_err <= 1'b1;
            end
            if (seed_ok) begin
                p17      <= seed_p17;
                p7       <= seed_p7;
                beat_cnt <= '0;
            end else if (beat_acc) begin
                p17      <= core_out;
                p7       <= p7_adv;
                beat_cnt <= cnt_inc;
            end
            if (beat_acc) begin
                out_valid <= 1'b1;
                out_data  <= core_out;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scrambler_seq_ctrl.sv
// Bench for scrambler_seq_ctrl: behavioural core plus scoreboard model of the
// sequencer, directed scenarios followed by a randomized stream.
module tb_scrambler_seq_ctrl;

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned INTERVAL = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             seed_valid;
    logic [63:0]      seed_p17;
    logic [410:0]     seed_p7;
    logic             seed_ready;
    logic             seed_req;
    logic             seed_err;
    logic             in_valid;
    logic [6:0]       in_bits;
    logic             in_ready;
    logic             out_valid;
    logic [63:0]      out_data;
    logic             out_ready;
    logic [63:0]      core_load;
    logic [410:0]     core_load_p7;
    logic [6:0]       core_serial;
    logic [63:0]      core_out;
    logic [CNT_W-1:0] beat_cnt;

    int total = 0;
    int bad   = 0;

    // Scoreboard model
    logic         m_need_seed;
    logic [63:0]  m_p17;
    logic [410:0] m_p7;
    int           m_cnt;
    logic         m_ov;
    logic [63:0]  m_od;
    logic         m_err;
    logic         m_in_ready;
    logic         got_in_ready;

    int taps[5] = '{31, 60, 190, 195, 245};

    always #5 clk = ~clk;

    scrambler_seq_ctrl #(.RESEED_INTERVAL(INTERVAL), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .seed_valid(seed_valid), .seed_p17(seed_p17), .seed_p7(seed_p7),
        .seed_ready(seed_ready), .seed_req(seed_req), .seed_err(seed_err),
        .in_valid(in_valid), .in_bits(in_bits), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .core_load(core_load), .core_load_p7(core_load_p7), .core_serial(core_serial),
        .core_out(core_out), .beat_cnt(beat_cnt)
    );

    function automatic logic [410:0] p7_shift(input logic [410:0] p, input logic d);
        logic [410:0] n;
        logic m;
        m = p[410];
        n = p << 1;
        n[0] = m ^ d;
        if (m) begin
            foreach (taps[j]) n[taps[j]] = ~n[taps[j]];
        end
        return n;
    endfunction

    function automatic logic [410:0] p7_adv7(input logic [410:0] p, input logic [6:0] b);
        logic [410:0] q = p;
        for (int i = 0; i < 7; i++) q = p7_shift(q, b[i]);
        return q;
    endfunction

    // Behavioural core: output LFSR shifts left, fed by its msb, the P7 msb and the data bit
    function automatic logic [63:0] core_fn(input logic [63:0] s, input logic [410:0] p, input logic [6:0] b);
        logic [63:0]  t = s;
        logic [410:0] q = p;
        for (int i = 0; i < 7; i++) begin
            t = {t[62:0], t[63] ^ q[410] ^ b[i]};
            q = p7_shift(q, b[i]);
        end
        return t;
    endfunction

    always_comb core_out = core_fn(core_load, core_load_p7, core_serial);

    function automatic logic [410:0] rand_p7();
        logic [410:0] p = '0;
        for (int i = 0; i < 13; i++) p = (p << 32) | 411'($urandom);
        return p;
    endfunction

    task automatic model_reset();
        m_need_seed = 1'b1; m_p17 = '0; m_p7 = '0; m_cnt = 0;
        m_ov = 1'b0; m_od = '0; m_err = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model with the accept decision it predicts
    task automatic apply(input logic sv, input logic [63:0] s17, input logic [410:0] s7,
                         input logic iv, input logic [6:0] b, input logic ordy);
        logic acc;
        logic [63:0] exp;
        seed_valid = sv; seed_p17 = s17; seed_p7 = s7;
        in_valid = iv; in_bits = b; out_ready = ordy;
        #1;
        got_in_ready = in_ready;
        m_in_ready = !m_need_seed && !sv && (!m_ov || ordy);
        @(posedge clk); #1;
        acc = iv && m_in_ready;
        if (acc) begin
            exp   = core_fn(m_p17, m_p7, b);
            m_od  = exp;
            m_ov  = 1'b1;
            m_p7  = p7_adv7(m_p7, b);
            m_p17 = exp;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (m_cnt == INTERVAL) m_need_seed = 1'b1;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        if (sv) begin
            if (s7 != '0) begin
                m_p17 = s17; m_p7 = s7; m_cnt = 0; m_need_seed = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
        seed_valid = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({seed_req, seed_ready, in_ready, out_valid, seed_err} !== 5'b11000) begin
            bad++; $display("FAIL reset_flags got=%b exp=11000", {seed_req, seed_ready, in_ready, out_valid, seed_err});
        end
        total++;
        if (out_data !== 64'h0 || beat_cnt !== '0) begin
            bad++; $display("FAIL reset_data got=%h/%0d exp=0/0", out_data, beat_cnt);
        end
        total++;
        if (core_load !== 64'h0 || core_load_p7 !== 411'h0) begin
            bad++; $display("FAIL reset_state got=%h exp=0", core_load);
        end
    endtask

    task automatic test_basic();
        apply(1'b1, 64'h0, 411'h1, 1'b0, 7'h0, 1'b1);
        apply(1'b0, '0, '0, 1'b1, 7'h00, 1'b1);
        total++;
        if (got_in_ready !== 1'b1) begin
            bad++; $display("FAIL basic_in_ready got=%b exp=1", got_in_ready);
        end
        total++;
        if (out_valid !== 1'b1 || out_data !== 64'h0 || beat_cnt !== 16'd1) begin
            bad++; $display("FAIL basic_out got=%b/%h/%0d exp=1/0/1", out_valid, out_data, beat_cnt);
        end
        total++;
        if (core_load_p7 !== 411'h80) begin
            bad++; $display("FAIL basic_p7 got=%h exp=80", core_load_p7);
        end
        apply(1'b1, 64'h1, 411'h1, 1'b0, 7'h0, 1'b1);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL basic_drain got=%b exp=0", out_valid);
        end
        apply(1'b0, '0, '0, 1'b1, 7'h00, 1'b1);
        total++;
        if (out_valid !== 1'b1 || out_data !== 64'h80) begin
            bad++; $display("FAIL basic_shift got=%b/%h exp=1/80", out_valid, out_data);
        end
    endtask

    task automatic test_seed_err();
        rst = 1'b1; #2; rst = 1'b0; model_reset();
        @(posedge clk); #1;
        apply(1'b1, 64'h1234, 411'h0, 1'b0, 7'h0, 1'b1);
        seed_valid = 1'b0; in_valid = 1'b1; #1;
        total++;
        if (seed_err !== 1'b1 || seed_req !== 1'b1 || in_ready !== 1'b0 || core_load !== 64'h0) begin
            bad++; $display("FAIL zero_seed got=err%b req%b rdy%b load%h exp=err1 req1 rdy0 load0",
                            seed_err, seed_req, in_ready, core_load);
        end
        in_valid = 1'b0;
        apply(1'b1, 64'h55, 411'h3, 1'b0, 7'h0, 1'b1);
        in_valid = 1'b1; #1;
        total++;
        if (seed_err !== 1'b1 || seed_req !== 1'b0 || in_ready !== 1'b1 || core_load !== 64'h55) begin
            bad++; $display("FAIL seed_after_err got=err%b req%b rdy%b load%h exp=err1 req0 rdy1 load55",
                            seed_err, seed_req, in_ready, core_load);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        logic [63:0] held;
        apply(1'b1, 64'hdead_beef_0bad_f00d, rand_p7() | 411'h1, 1'b0, 7'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, '0, '0, 1'b1, 7'($urandom), 1'b0);
            if (got_in_ready) accepted++;
            if (i == 0) held = out_data;
        end
        total++;
        if (accepted != 1) begin
            bad++; $display("FAIL bp_accept_count got=%0d exp=1", accepted);
        end
        total++;
        if (out_valid !== 1'b1 || out_data !== m_od || held !== m_od) begin
            bad++; $display("FAIL bp_stable got=%h first=%h exp=%h", out_data, held, m_od);
        end
        apply(1'b0, '0, '0, 1'b1, 7'h5a, 1'b1);
        total++;
        if (got_in_ready !== 1'b1 || out_data !== m_od || beat_cnt !== 16'd2) begin
            bad++; $display("FAIL bp_release got=%b/%h/%0d exp=1/%h/2", got_in_ready, out_data, beat_cnt, m_od);
        end
    endtask

    task automatic test_reseed();
        int accepted = 0;
        apply(1'b1, 64'h0123_4567_89ab_cdef, rand_p7() | 411'h1, 1'b0, 7'h0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, '0, '0, 1'b1, 7'($urandom), 1'b1);
            if (got_in_ready) accepted++;
        end
        total++;
        if (accepted != 4 || seed_req !== 1'b1 || beat_cnt !== 16'd4) begin
            bad++; $display("FAIL reseed_stop got=%0d/%b/%0d exp=4/1/4", accepted, seed_req, beat_cnt);
        end
        apply(1'b1, 64'hfeed_face_cafe_babe, rand_p7() | 411'h1, 1'b0, 7'h0, 1'b1);
        for (int i = 0; i < 2; i++) apply(1'b0, '0, '0, 1'b1, 7'($urandom), 1'b1);
        total++;
        if (beat_cnt !== 16'd2 || out_data !== m_od || out_valid !== 1'b1 || seed_req !== 1'b0) begin
            bad++; $display("FAIL reseed_resume got=%0d/%h/%b exp=2/%h/1", beat_cnt, out_data, out_valid, m_od);
        end
    endtask

    task automatic test_seed_wins();
        apply(1'b1, 64'h1111, rand_p7() | 411'h1, 1'b0, 7'h0, 1'b1);
        apply(1'b0, '0, '0, 1'b1, 7'h33, 1'b1);
        apply(1'b1, 64'h2222, 411'h7, 1'b1, 7'h44, 1'b1);
        total++;
        if (got_in_ready !== 1'b0 || core_load !== 64'h2222 || core_load_p7 !== 411'h7 || beat_cnt !== '0) begin
            bad++; $display("FAIL seed_wins got=rdy%b load%h cnt%0d exp=rdy0 load2222 cnt0", got_in_ready, core_load, beat_cnt);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL seed_wins_ov got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_random();
        logic sv, iv, ordy;
        logic [410:0] s7;
        for (int it = 0; it < 300; it++) begin
            sv   = m_need_seed ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
            s7   = ($urandom_range(15) == 0) ? 411'h0 : rand_p7();
            iv   = $urandom_range(3) != 0;
            ordy = $urandom_range(2) != 0;
            apply(sv, {$urandom, $urandom}, s7, iv, 7'($urandom), ordy);
            total++;
            if (got_in_ready !== m_in_ready) begin
                bad++; $display("FAIL rnd_in_ready it=%0d got=%b exp=%b", it, got_in_ready, m_in_ready);
            end
            total++;
            if (out_valid !== m_ov || (m_ov && out_data !== m_od)) begin
                bad++; $display("FAIL rnd_out it=%0d got=%b/%h exp=%b/%h", it, out_valid, out_data, m_ov, m_od);
            end
            total++;
            if (beat_cnt !== CNT_W'(m_cnt) || seed_req !== m_need_seed || seed_err !== m_err) begin
                bad++; $display("FAIL rnd_ctrl it=%0d got=%0d/%b/%b exp=%0d/%b/%b", it, beat_cnt, seed_req, seed_err, m_cnt, m_need_seed, m_err);
            end
            total++;
            if (core_load !== m_p17 || core_load_p7 !== m_p7) begin
                bad++; $display("FAIL rnd_state it=%0d got=%h exp=%h", it, core_load, m_p17);
            end
        end
    endtask

    task automatic test_rst_mid();
        apply(1'b1, 64'habcd, rand_p7() | 411'h1, 1'b0, 7'h0, 1'b1);
        apply(1'b0, '0, '0, 1'b1, 7'h12, 1'b0);
        seed_valid = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        total++;
        if ({seed_req, seed_ready, in_ready, out_valid, seed_err} !== 5'b11000 || out_data !== 64'h0 ||
            beat_cnt !== '0 || core_load !== 64'h0 || core_load_p7 !== 411'h0) begin
            bad++; $display("FAIL rst_mid got=%b/%h/%0d exp=11000/0/0",
                            {seed_req, seed_ready, in_ready, out_valid, seed_err}, out_data, beat_cnt);
        end
        in_valid = 1'b0;
        #3 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; seed_valid = 1'b0; seed_p17 = '0; seed_p7 = '0;
        in_valid = 1'b0; in_bits = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_basic();
        test_seed_err();
        test_backpressure();
        test_reseed();
        test_seed_wins();
        test_random();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
